// File: rtl/fifo_stream_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_stream_arbiter
//
// Round-robin arbiter that shares one FIFO write port between NUM_REQ
// valid/ready producer streams. A granted requester owns the FIFO input for a
// burst. The burst ends on the requester's s_last flag or after MAX_BURST beats,
// whichever comes first. Each beat is tagged with its source ID on m_id so the
// FIFO consumer can demultiplex.
//
// Optional build macro:
//   ARB_WATCHDOG_EN - when defined, a requester that holds the grant with its
//                     valid low for TIMEOUT consecutive cycles loses the grant.
//                     No beat and no m_last are produced for that release.
//
// Ports:
//   clk      in   1               clock
//   resetn   in   1               synchronous, active-low reset
//   s_data   in   NUM_REQ*WIDTH   requester data, requester i at [i*WIDTH +: WIDTH]
//   s_valid  in   NUM_REQ         per-requester valid
//   s_last   in   NUM_REQ         per-requester end-of-burst flag
//   s_ready  out  NUM_REQ         per-requester ready
//   m_data   out  WIDTH           data to the FIFO
//   m_id     out  LOG_REQ         source ID of the current beat
//   m_valid  out  1               valid to the FIFO
//   m_last   out  1               final beat of the current grant
//   m_ready  in   1               FIFO ready
//   busy     out  1               high while a grant is held (LOCK)
// -----------------------------------------------------------------------------
module fifo_stream_arbiter #(
    parameter int WIDTH     = 72,
    parameter int NUM_REQ   = 4,
    parameter int LOG_REQ   = 2,
    parameter int MAX_BURST = 16,
    parameter int LOG_BURST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ*WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]       s_valid,
    input  logic [NUM_REQ-1:0]       s_last,
    output logic [NUM_REQ-1:0]       s_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic [LOG_REQ-1:0]       m_id,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     busy
);

    // Parameter sanity: the ID and beat counters rely on power-of-two sizes
    // wrapping naturally, and the stall counter needs at least one bit.
    if (NUM_REQ != (1 << LOG_REQ)) begin : g_bad_num_req
        $error("fifo_stream_arbiter: NUM_REQ must equal 2**LOG_REQ");
    end
    if (MAX_BURST != (1 << LOG_BURST)) begin : g_bad_max_burst
        $error("fifo_stream_arbiter: MAX_BURST must equal 2**LOG_BURST");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("fifo_stream_arbiter: TIMEOUT must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LOG_REQ-1:0]   grant;
    logic [LOG_REQ-1:0]   last_grant;
    logic [LOG_REQ-1:0]   winner;
    logic                 any_valid;
    logic [LOG_BURST-1:0] beat_cnt;
    logic                 beat;
    logic                 release_grant;

`ifdef ARB_WATCHDOG_EN
    localparam int STALL_W = $clog2(TIMEOUT);
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_expired;

    // Release when this stall cycle would be the TIMEOUT-th in a row.
    assign stall_expired = (state == LOCK) && !s_valid[grant] &&
                           (stall_cnt == STALL_W'(TIMEOUT - 1));
`endif

    // Round-robin search: look upward from last_grant+1. The index sum is
    // LOG_REQ bits wide, so it wraps modulo NUM_REQ; offset NUM_REQ lands on
    // last_grant itself, giving it the lowest priority.
    // NOTE: every variable written in a combinational block gets a default
    // first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner    = last_grant;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_valid && s_valid[last_grant + LOG_REQ'(i)]) begin
                winner    = last_grant + LOG_REQ'(i);
                any_valid = 1'b1;
            end
        end
    end

    // Next state and the LOCK pass-through. The data path is purely
    // combinational so a granted beat costs no extra latency.
    always_comb begin
        state_nxt     = state;
        s_ready       = '0;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        m_data        = s_data[int'(grant) * WIDTH +: WIDTH];
        m_id          = grant;
        beat          = 1'b0;
        release_grant = 1'b0;

        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                // Gating with resetn guarantees nothing transfers in a reset
                // cycle, so an interrupted burst is simply dropped.
                m_valid        = resetn && s_valid[grant];
                s_ready[grant] = resetn && m_ready;
                m_last         = m_valid &&
                                 (s_last[grant] || (beat_cnt == LOG_BURST'(MAX_BURST - 1)));
                beat           = m_valid && m_ready;
                if (beat && m_last) begin
                    release_grant = 1'b1;
                    state_nxt     = IDLE;
                end
`ifdef ARB_WATCHDOG_EN
                else if (stall_expired) begin
                    release_grant = 1'b1;
                    state_nxt     = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping and beat counter. The beat counter never wraps on its
    // own: the beat that reaches MAX_BURST-1 forces m_last and a release.
    // NOTE: reset is synchronous, so every control register is cleared here on
    // the clock edge; the data path itself holds no storage to reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant      <= '0;
            last_grant <= LOG_REQ'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (any_valid) begin
                        grant <= winner;
                    end
                end
                LOCK: begin
                    if (release_grant) begin
                        last_grant <= grant;
                        beat_cnt   <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: beat_cnt <= '0;
            endcase
        end
    end

`ifdef ARB_WATCHDOG_EN
    // Counts consecutive LOCK cycles with the granted valid low; any valid
    // cycle, any release or leaving LOCK starts the count again.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (state == LOCK && !s_valid[grant] && !release_grant) begin
            stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end
`endif

    assign busy = (state == LOCK);

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_arbiter
//
// Directed bench for fifo_stream_arbiter. Each requester is a small producer
// model (beats remaining, sequence number, burst length for s_last) that only
// advances when its beat is accepted. Expected beats are queued when a
// scenario is set up and compared against every m_valid && m_ready beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_stream_arbiter;

    localparam int WIDTH     = 72;
    localparam int NUM_REQ   = 4;
    localparam int LOG_REQ   = 2;
    localparam int MAX_BURST = 16;
    localparam int LOG_BURST = 4;
    localparam int TIMEOUT   = 64;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [NUM_REQ*WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0]       s_valid;
    logic [NUM_REQ-1:0]       s_last;
    logic [NUM_REQ-1:0]       s_ready;
    logic [WIDTH-1:0]         m_data;
    logic [LOG_REQ-1:0]       m_id;
    logic                     m_valid;
    logic                     m_last;
    logic                     m_ready;
    logic                     busy;

    fifo_stream_arbiter #(
        .WIDTH    (WIDTH),
        .NUM_REQ  (NUM_REQ),
        .LOG_REQ  (LOG_REQ),
        .MAX_BURST(MAX_BURST),
        .LOG_BURST(LOG_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_last (s_last),
        .s_ready(s_ready),
        .m_data (m_data),
        .m_id   (m_id),
        .m_valid(m_valid),
        .m_last (m_last),
        .m_ready(m_ready),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]   data;
        logic [LOG_REQ-1:0] id;
        logic               last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    // Producer model state.
    int rem  [NUM_REQ];
    int seq  [NUM_REQ];
    int blen [NUM_REQ];
    int pos  [NUM_REQ];

    logic [NUM_REQ-1:0] fire_s;
    int   cyc        = 0;
    int   last_cyc   = 0;
    logic prev_last  = 1'b0;
    logic bubble_chk = 1'b0;

    function automatic logic [WIDTH-1:0] mk(int id, int s);
        logic [7:0] tag;
        tag = 8'hC0 | 8'(id);
        return {tag, 32'(s) ^ 32'h5A5A_0000, 32'(s)};
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            s_valid[i]                  = (rem[i] > 0);
            s_last[i]                   = (blen[i] != 0) && (pos[i] == blen[i] - 1);
            s_data[i*WIDTH +: WIDTH]    = mk(i, seq[i]);
        end
    endtask

    // Advance one clock; producers whose beat was accepted move on.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire_s[i]) begin
                rem[i]--;
                seq[i]++;
                pos[i] = ((blen[i] != 0) && (pos[i] == blen[i] - 1)) ? 0 : pos[i] + 1;
            end
        end
        drive_inputs();
    endtask

    task automatic expect_burst(int id, int s0, int n, bit last_end);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data = mk(id, s0 + k);
            e.id   = LOG_REQ'(id);
            e.last = last_end && (k == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic set_req(int id, int n, int bl);
        rem[id]  = n;
        blen[id] = bl;
        pos[id]  = 0;
    endtask

    task automatic wait_done(string tag, int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check(tag, (n < budget), 1'b1);
    endtask

    // Sampling and scoreboard monitor, on the falling edge.
    always @(negedge clk) begin
        cyc++;
        fire_s = s_valid & s_ready;
        if (!resetn) begin
            prev_last = 1'b0;
        end else if (m_valid && m_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_underflow: observed beat id=%0d data=%0h expected no beat", m_id, m_data);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("beat_data", m_data, mon_e.data);
                check("beat_id",   m_id,   mon_e.id);
                check("beat_last", m_last, mon_e.last);
            end
            if (bubble_chk && prev_last) begin
                check("bubble_gap", cyc - last_cyc, 2);
            end
            prev_last = m_last;
            last_cyc  = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: observed no finish expected finish before 200000ns");
        $fatal(1, "tb_timeout");
    end

    initial begin
        int s0;
        int n;

        // ---------------- Reset state, with requests pending ----------------
        resetn  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i] = 0;
            set_req(i, 1, 1);
        end
        drive_inputs();
        tick();
        tick();
        @(negedge clk);
        check("rst_s_ready", s_ready, '0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last",  m_last,  1'b0);
        check("rst_busy",    busy,    1'b0);
        check("rst_grant",   m_id,    '0);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0);
        drive_inputs();
        tick();
        resetn = 1'b1;
        tick();

        // ---------------- Single requester, 5-beat burst ----------------
        expect_burst(2, seq[2], 5, 1'b1);
        set_req(2, 5, 5);
        drive_inputs();
        @(negedge clk);
        check("t1_busy_pre",  busy,    1'b0);
        check("t1_idle_valid", m_valid, 1'b0);
        check("t1_idle_ready", s_ready, '0);
        tick();
        @(negedge clk);
        check("t1_busy_rise", busy,    1'b1);
        check("t1_valid",     m_valid, 1'b1);
        check("t1_id",        m_id,    2'd2);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        check("t1_busy_cycles", n, 5);
        check("t1_sb_empty", sb.size(), 0);

        // ---------------- Full contention after reset ----------------
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        set_req(0, 32, 0);
        set_req(1, 16, 0);
        set_req(2, 16, 0);
        set_req(3, 16, 0);
        expect_burst(0, seq[0],      16, 1'b1);
        expect_burst(1, seq[1],      16, 1'b1);
        expect_burst(2, seq[2],      16, 1'b1);
        expect_burst(3, seq[3],      16, 1'b1);
        expect_burst(0, seq[0] + 16, 16, 1'b1);
        bubble_chk = 1'b1;
        drive_inputs();
        wait_done("t2_done", 200);
        bubble_chk = 1'b0;

        // ---------------- Backpressure at beat 7 ----------------
        s0 = seq[1];
        expect_burst(1, s0, 16, 1'b1);
        set_req(1, 16, 0);
        drive_inputs();
        n = 0;
        while ((seq[1] - s0) < 6 && n < 100) begin
            tick();
            n++;
        end
        check("t3_reach_beat7", (n < 100), 1'b1);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_data",  m_data,       mk(1, s0 + 6));
            check("t3_hold_valid", m_valid,      1'b1);
            check("t3_hold_ready", s_ready,      '0);
            check("t3_beat_cnt",   dut.beat_cnt, 6);
            tick();
        end
        m_ready = 1'b1;
        wait_done("t3_done", 100);

        // ---------------- Priority rotation from last_grant=3 ----------------
        expect_burst(3, seq[3], 1, 1'b1);
        set_req(3, 1, 1);
        drive_inputs();
        wait_done("t4_prep", 20);
        expect_burst(0, seq[0], 2, 1'b1);
        expect_burst(3, seq[3], 2, 1'b1);
        set_req(0, 2, 2);
        set_req(3, 2, 2);
        drive_inputs();
        tick();
        @(negedge clk);
        check("t4_first_winner", m_id, 2'd0);
        wait_done("t4_done", 30);

        // ---------------- Stalled requester 1, requester 3 waiting ----------------
        s0 = seq[1];
        expect_burst(1, s0, 2, 1'b0);
        set_req(1, 2, 0);
        set_req(3, 3, 3);
        drive_inputs();
        n = 0;
        while ((seq[1] - s0) < 2 && n < 20) begin
            tick();
            n++;
        end
        check("t5_two_beats", (n < 20), 1'b1);
`ifdef ARB_WATCHDOG_EN
        expect_burst(3, seq[3], 3, 1'b1);
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            check("t5_stall_no_last", m_last, 1'b0);
            n++;
            tick();
            @(negedge clk);
        end
        check("t5_wd_stall_cycles", n, TIMEOUT);
        wait_done("t5_done", 30);
`else
        repeat (200) tick();
        @(negedge clk);
        check("t5_hold_busy",  busy,    1'b1);
        check("t5_hold_grant", m_id,    2'd1);
        check("t5_hold_valid", m_valid, 1'b0);
        expect_burst(1, seq[1], 1, 1'b1);
        expect_burst(3, seq[3], 3, 1'b1);
        set_req(1, 1, 1);
        drive_inputs();
        wait_done("t5_done", 30);
`endif

        // ---------------- Reset in the middle of a burst ----------------
        s0 = seq[1];
        expect_burst(1, s0, 3, 1'b0);
        set_req(1, 16, 0);
        drive_inputs();
        n = 0;
        while ((seq[1] - s0) < 3 && n < 20) begin
            tick();
            n++;
        end
        check("t6_three_beats", (n < 20), 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_rst_ready", s_ready, '0);
        check("t6_rst_valid", m_valid, 1'b0);
        check("t6_rst_last",  m_last,  1'b0);
        tick();
        check("t6_sb_flushed", sb.size(), 0);
        set_req(1, 0, 0);
        set_req(0, 1, 1);
        set_req(2, 1, 1);
        set_req(3, 1, 1);
        drive_inputs();
        @(negedge clk);
        check("t6_rst_busy", busy, 1'b0);
        expect_burst(0, seq[0], 1, 1'b1);
        expect_burst(2, seq[2], 1, 1'b1);
        expect_burst(3, seq[3], 1, 1'b1);
        tick();
        resetn = 1'b1;
        wait_done("t6_done", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
